chunk_router_ctrl: RTL and testbench

- Steers a stream of Nin-bit chunks from a single link to one of K downstream per-destination deserializers.
- Each packet is one header chunk followed by exactly D payload chunks. The header selects the destination. Payload chunks are forwarded with a zero-latency valid/ack pass-through.
- Packets with an out-of-range destination are consumed and dropped.
- Sits between the FPGA link receiver and the bank of chunk-to-word deserializers.

---
 rtl/chunk_router_ctrl.sv | 114 +++++++++++
 tb/tb_chunk_router_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/chunk_router_ctrl.sv
// Routes header-prefixed packets of Nin-bit chunks to one of K destinations.
// Payload chunks pass through combinationally; headers naming an invalid destination cause the packet to be dropped.
module chunk_router_ctrl #(
    parameter int Nin  = 4,
    parameter int K    = 3,
    parameter int D    = 4,
    parameter int Ncnt = 16,
    localparam int W   = $clog2(K)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_v,
    input  logic [Nin-1:0]  in_d,
    output logic            in_a,
    output logic [K-1:0]    out_v,
    output logic [Nin-1:0]  out_d,
    input  logic [K-1:0]    out_a,
    output logic [W-1:0]    cur_dest,
    output logic            busy,
    output logic [Ncnt-1:0] pkt_count,
    output logic [Ncnt-1:0] drop_count
);

    localparam int CW = $clog2(D + 1);

    localparam logic [1:0] HEADER  = 2'd0;
    localparam logic [1:0] FORWARD = 2'd1;
    localparam logic [1:0] DROP    = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  hdr_id;
    logic          hdr_ok;
    logic          sel_a;
    logic          xfer;
    logic          last;

    function automatic logic [Ncnt-1:0] sat_inc(input logic [Ncnt-1:0] v);
        return (&v) ? v : v + Ncnt'(1);
    endfunction

    assign hdr_id = in_d[W-1:0];
    assign hdr_ok = (32'(hdr_id) < K);
    assign out_d  = in_d;
    assign busy   = (state != HEADER);
    assign xfer   = in_v & in_a;
    assign last   = (cnt == CW'(D - 1));

    // Destination decode is written as a compare loop so that ids >= K never index out_v/out_a.
    always_comb begin
        out_v = '0;
        sel_a = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (cur_dest == W'(i)) begin
                out_v[i] = (state == FORWARD) & in_v;
                sel_a    = out_a[i];
            end
        end
    end

    always_comb begin
        in_a = 1'b0;
        case (state)
            HEADER:  in_a = in_v;
            FORWARD: in_a = in_v & sel_a;
            DROP:    in_a = in_v;
            default: in_a = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HEADER;
            cnt        <= '0;
            cur_dest   <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
        end else if (state != HEADER && state != FORWARD && state != DROP) begin
            state <= HEADER;
            cnt   <= '0;
        end else if (xfer) begin
            case (state)
                HEADER: begin
                    cnt <= '0;
                    if (hdr_ok) begin
                        cur_dest <= hdr_id;
                        state    <= FORWARD;
                    end else begin
                        state <= DROP;
                    end
                end
                FORWARD: begin
                    if (last) begin
                        state     <= HEADER;
                        cnt       <= '0;
                        pkt_count <= sat_inc(pkt_count);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    if (last) begin
                        state      <= HEADER;
                        cnt        <= '0;
                        drop_count <= sat_inc(drop_count);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunk_router_ctrl.sv
// Bench for chunk_router_ctrl: directed packets with literal expectations, then random traffic
// against a packet-position model; a second instance with 2-bit counters covers saturation.
module tb_chunk_router_ctrl;

    localparam int NIN = 4;
    localparam int K   = 3;
    localparam int D   = 4;
    localparam int MW  = $clog2(K);

    logic           clk = 1'b0;
    logic           reset;
    logic           in_v;
    logic [NIN-1:0] in_d;
    logic [K-1:0]   out_a;

    logic           in_a, busy;
    logic [K-1:0]   out_v;
    logic [NIN-1:0] out_d;
    logic [MW-1:0]  cur_dest;
    logic [15:0]    pkt_count, drop_count;

    logic           s_in_a, s_busy;
    logic [K-1:0]   s_out_v;
    logic [NIN-1:0] s_out_d;
    logic [MW-1:0]  s_cur_dest;
    logic [1:0]     s_pkt, s_drop;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Model: position within the current packet (0 = next chunk is a header).
    int m_pos = 0;
    int m_cur = 0;
    bit m_drop = 1'b0;
    int m_pkt = 0, m_dcnt = 0, m_pkt2 = 0, m_dcnt2 = 0;

    always #5 clk = ~clk;

    chunk_router_ctrl #(.Nin(NIN), .K(K), .D(D), .Ncnt(16)) dut (
        .clk(clk), .reset(reset), .in_v(in_v), .in_d(in_d), .in_a(in_a),
        .out_v(out_v), .out_d(out_d), .out_a(out_a), .cur_dest(cur_dest),
        .busy(busy), .pkt_count(pkt_count), .drop_count(drop_count)
    );

    chunk_router_ctrl #(.Nin(NIN), .K(K), .D(D), .Ncnt(2)) dut_sat (
        .clk(clk), .reset(reset), .in_v(in_v), .in_d(in_d), .in_a(s_in_a),
        .out_v(s_out_v), .out_d(s_out_d), .out_a(out_a), .cur_dest(s_cur_dest),
        .busy(s_busy), .pkt_count(s_pkt), .drop_count(s_drop)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_in_a();
        if (m_pos == 0 || m_drop) return in_v;
        return in_v & out_a[m_cur];
    endfunction

    function automatic logic [K-1:0] m_out_v();
        if (m_pos == 0 || m_drop || !in_v) return '0;
        return K'(1 << m_cur);
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_pos = 0; m_cur = 0; m_drop = 1'b0;
            m_pkt = 0; m_dcnt = 0; m_pkt2 = 0; m_dcnt2 = 0;
        end else if (in_v && m_in_a()) begin
            if (m_pos == 0) begin
                if (int'(in_d) % (1 << MW) < K) begin
                    m_cur  = int'(in_d) % (1 << MW);
                    m_drop = 1'b0;
                end else begin
                    m_drop = 1'b1;
                end
                m_pos = 1;
            end else if (m_pos == D) begin
                if (m_drop) begin
                    m_dcnt = sat(m_dcnt, 65535); m_dcnt2 = sat(m_dcnt2, 3);
                end else begin
                    m_pkt = sat(m_pkt, 65535); m_pkt2 = sat(m_pkt2, 3);
                end
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("in_a", 32'(in_a), 32'(m_in_a()));
            chk("out_v", 32'(out_v), 32'(m_out_v()));
            if (out_v != '0) chk("out_d", 32'(out_d), 32'(in_d));
            chk("busy", 32'(busy), 32'(m_pos != 0));
            chk("cur_dest", 32'(cur_dest), 32'(m_cur));
            chk("pkt_count", 32'(pkt_count), 32'(m_pkt));
            chk("drop_count", 32'(drop_count), 32'(m_dcnt));
            chk("sat_pkt", 32'(s_pkt), 32'(m_pkt2));
            chk("sat_drop", 32'(s_drop), 32'(m_dcnt2));
            chk("sat_in_a", 32'(s_in_a), 32'(m_in_a()));
        end
    end

    task automatic drive(input logic v, input logic [NIN-1:0] d, input logic [K-1:0] a);
        in_v = v; in_d = d; out_a = a;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [NIN-1:0] hdr, input logic [NIN-1:0] base);
        drive(1'b1, hdr, 3'b111); tick();
        for (int i = 0; i < D; i++) begin
            drive(1'b1, base + NIN'(i), 3'b111); tick();
        end
    endtask

    initial begin
        reset = 1'b1; in_v = 1'b0; in_d = '0; out_a = '0;
        tick(); tick();
        reset = 1'b0;
        started = 1'b1;
        drive(1'b0, 4'h0, 3'b000);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_v", 32'(out_v), 32'd0);
        chk("rst_pkt", 32'(pkt_count), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_in_a", 32'(in_a), 32'd0);

        // Header 1 then A..D to destination 1.
        drive(1'b1, 4'h1, 3'b111); tick();
        for (int i = 0; i < D; i++) begin
            drive(1'b1, 4'hA + 4'(i), 3'b111);
            chk("p1_out_v", 32'(out_v), 32'b010);
            chk("p1_out_d", 32'(out_d), 32'hA + 32'(i));
            tick();
        end
        drive(1'b0, 4'h0, 3'b111);
        chk("p1_pkt", 32'(pkt_count), 32'd1);
        chk("p1_busy", 32'(busy), 32'd0);

        // Header 3 is out of range: dropped.
        drive(1'b1, 4'h3, 3'b000); tick();
        for (int i = 0; i < D; i++) begin
            drive(1'b1, 4'(i), 3'b000);
            chk("drop_in_a", 32'(in_a), 32'd1);
            chk("drop_out_v", 32'(out_v), 32'd0);
            tick();
        end
        drive(1'b0, 4'h0, 3'b000);
        chk("drop_cnt", 32'(drop_count), 32'd1);
        chk("drop_pkt", 32'(pkt_count), 32'd1);

        // Header 2 with a 3-cycle stall on payload 2; other acks toggled.
        drive(1'b1, 4'h2, 3'b000); tick();
        drive(1'b1, 4'h5, 3'b100); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'h6, (i % 2 == 0) ? 3'b011 : 3'b001);
            chk("stall_in_a", 32'(in_a), 32'd0);
            chk("stall_out_v", 32'(out_v), 32'b100);
            tick();
        end
        drive(1'b1, 4'h6, 3'b100); tick();
        drive(1'b1, 4'h7, 3'b100); tick();
        drive(1'b1, 4'h8, 3'b100);
        chk("stall_busy", 32'(busy), 32'd1);
        tick();
        drive(1'b0, 4'h0, 3'b000);
        chk("stall_pkt", 32'(pkt_count), 32'd2);

        // Back-to-back dest 0 then dest 2, no bubble.
        drive(1'b1, 4'h0, 3'b111); tick();
        chk("b2b_dest0", 32'(cur_dest), 32'd0);
        for (int i = 0; i < D; i++) begin drive(1'b1, 4'(i), 3'b111); tick(); end
        drive(1'b1, 4'h2, 3'b111);
        chk("b2b_hdr_in_a", 32'(in_a), 32'd1);
        tick();
        chk("b2b_dest2", 32'(cur_dest), 32'd2);
        for (int i = 0; i < D; i++) begin drive(1'b1, 4'(i), 3'b111); tick(); end
        drive(1'b0, 4'h0, 3'b000);
        chk("b2b_pkt", 32'(pkt_count), 32'd4);

        // Header 0xE routes to 2; reset mid-packet aborts it.
        drive(1'b1, 4'hE, 3'b111); tick();
        chk("hiE_dest", 32'(cur_dest), 32'd2);
        drive(1'b1, 4'h1, 3'b111); tick();
        drive(1'b1, 4'h2, 3'b111); tick();
        drive(1'b0, 4'h0, 3'b111);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_pkt", 32'(pkt_count), 32'd0);
        chk("abort_drop", 32'(drop_count), 32'd0);
        drive(1'b1, 4'h0, 3'b111); tick();
        chk("abort_hdr_dest", 32'(cur_dest), 32'd0);
        chk("abort_hdr_busy", 32'(busy), 32'd1);
        for (int i = 0; i < D; i++) begin drive(1'b1, 4'(i), 3'b111); tick(); end

        // Saturation: 4 more packets push the 2-bit counter past 3.
        for (int p = 0; p < 4; p++) send_pkt(4'h1, 4'h9);
        drive(1'b0, 4'h0, 3'b000);
        chk("sat_hold", 32'(s_pkt), 32'd3);
        chk("nosat_pkt", 32'(pkt_count), 32'd5);

        // Random traffic checked cycle-by-cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 399) == 0);
            drive(($urandom_range(0, 9) < 7), NIN'($urandom), K'($urandom));
            tick();
        end
        reset = 1'b0;
        drive(1'b0, 4'h0, 3'b000);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
